// File: rtl/rescale_stream_pkg.sv
// Shared widths, rounding/numerator constants and state encoding for the min-max rescaler.
package rescale_stream_pkg;
   localparam int unsigned NB_PIXEL = 19;
   localparam int unsigned NB_OUT   = 8;
   localparam int unsigned NEW_MAX  = 255;
   localparam int unsigned NEW_MIN  = 0;
   localparam int unsigned NB_FRAC  = 16;
   localparam int unsigned NB_SCALE = NB_OUT + NB_FRAC;
   localparam int unsigned NB_RANGE = NB_PIXEL + 1;
   localparam int unsigned NB_PROD  = NB_RANGE + NB_SCALE;
   localparam int unsigned HALF     = 1 << (NB_FRAC - 1);
   localparam int unsigned NUM      = (NEW_MAX - NEW_MIN) << NB_FRAC;

   typedef enum logic [1:0] {
      ACC = 2'd0,
      DIV = 2'd1,
      RUN = 2'd2
   } state_t;
endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; a zero divisor yields a zero quotient.
module seq_divider #(
   parameter int unsigned NB_NUM = 24,
   parameter int unsigned NB_DEN = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NB_NUM-1:0] num,
   input  logic [NB_DEN-1:0] den,
   output logic              busy,
   output logic              done,
   output logic [NB_NUM-1:0] quot
);
   localparam int unsigned NB_CNT = $clog2(NB_NUM + 1);

   logic [NB_NUM-1:0] dvd_q;
   logic [NB_DEN-1:0] den_q;
   logic [NB_DEN-1:0] rem_q;
   logic [NB_CNT-1:0] cnt_q;
   logic              zero_q;
   logic [NB_DEN:0]   trial_c;
   logic [NB_DEN-1:0] diff_c;
   logic              ge_c;

   // The remainder stays below the divisor, so the difference fits without its top bit
   always_comb begin
      trial_c = {rem_q, dvd_q[NB_NUM-1]};
      ge_c    = (trial_c >= {1'b0, den_q});
      diff_c  = trial_c[NB_DEN-1:0] - den_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         zero_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         quot   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            dvd_q  <= num;
            den_q  <= den;
            rem_q  <= '0;
            cnt_q  <= NB_CNT'(NB_NUM);
            zero_q <= (den == '0);
            busy   <= 1'b1;
            quot   <= '0;
         end else if (busy) begin
            dvd_q <= dvd_q << 1;
            rem_q <= ge_c ? diff_c : trial_c[NB_DEN-1:0];
            cnt_q <= cnt_q - NB_CNT'(1);
            if (cnt_q == NB_CNT'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
               quot <= zero_q ? '0 : {quot[NB_NUM-2:0], ge_c};
            end else begin
               quot <= {quot[NB_NUM-2:0], ge_c};
            end
         end
      end
   end
endmodule

// File: rtl/rescale_stream.sv
// Two-pass min-max contrast rescaler: track frame extremes, divide for a scale, then map pixels.
module rescale_stream
   import rescale_stream_pkg::*;
(
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic signed [NB_PIXEL-1:0] i_pixel,
   input  logic                       i_endSignal,
   output logic                       o_ready,
   output logic                       o_valid,
   output logic [NB_OUT-1:0]          o_pixel,
   output logic signed [NB_PIXEL-1:0] o_maxByte,
   output logic signed [NB_PIXEL-1:0] o_minByte,
   output logic                       o_done
);
   localparam int unsigned NB_RND = NB_PROD + 1;
   localparam logic signed [NB_PIXEL-1:0] PIX_MAX = {1'b0, {(NB_PIXEL-1){1'b1}}};
   localparam logic signed [NB_PIXEL-1:0] PIX_MIN = {1'b1, {(NB_PIXEL-1){1'b0}}};

   state_t                      state_q, state_d;
   logic signed [NB_PIXEL-1:0]  run_min_q, run_min_d, run_max_q, run_max_d;
   logic signed [NB_PIXEL-1:0]  min_byte_d, max_byte_d;
   logic                        seen_q, seen_d;
   logic                        ready_d;
   logic [NB_SCALE-1:0]         scale_q, scale_d;
   logic [NB_RANGE-1:0]         range_c;
   logic                        div_start_c, div_busy, div_done;
   logic [NB_SCALE-1:0]         div_quot;

   logic                        v1_q, d1_q, v2_q, d2_q;
   logic [NB_RANGE-1:0]         diff_c, diff1_q;
   logic [NB_PROD-1:0]          prod2_q;
   logic [NB_RND-1:0]           rnd_c;
   logic [NB_OUT-1:0]           pix_c;

   // Next-state logic; a pixel coincident with the end pulse is folded in before latching
   always_comb begin
      state_d     = state_q;
      run_min_d   = run_min_q;
      run_max_d   = run_max_q;
      seen_d      = seen_q;
      min_byte_d  = o_minByte;
      max_byte_d  = o_maxByte;
      scale_d     = scale_q;
      div_start_c = 1'b0;
      unique case (state_q)
         ACC: begin
            if (i_valid && o_ready) begin
               if (i_pixel < run_min_q) run_min_d = i_pixel;
               if (i_pixel > run_max_q) run_max_d = i_pixel;
               seen_d = 1'b1;
            end
            if (i_endSignal && o_ready && !div_busy) begin
               min_byte_d  = seen_d ? run_min_d : '0;
               max_byte_d  = seen_d ? run_max_d : '0;
               div_start_c = 1'b1;
               state_d     = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               scale_d = div_quot;
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_endSignal) begin
               state_d   = ACC;
               run_min_d = PIX_MAX;
               run_max_d = PIX_MIN;
               seen_d    = 1'b0;
            end
         end
         default: state_d = ACC;
      endcase
      ready_d = (state_d != DIV);
      range_c = {max_byte_d[NB_PIXEL-1], max_byte_d} - {min_byte_d[NB_PIXEL-1], min_byte_d};
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ACC;
         run_min_q <= PIX_MAX;
         run_max_q <= PIX_MIN;
         seen_q    <= 1'b0;
         scale_q   <= '0;
         o_ready   <= 1'b0;
         o_minByte <= '0;
         o_maxByte <= '0;
      end else begin
         state_q   <= state_d;
         run_min_q <= run_min_d;
         run_max_q <= run_max_d;
         seen_q    <= seen_d;
         scale_q   <= scale_d;
         o_ready   <= ready_d;
         o_minByte <= min_byte_d;
         o_maxByte <= max_byte_d;
      end
   end

   seq_divider #(
      .NB_NUM (NB_SCALE),
      .NB_DEN (NB_RANGE)
   ) u_div (
      .clk   (i_clock),
      .rst_n (i_reset),
      .start (div_start_c),
      .num   (NB_SCALE'(NUM)),
      .den   (range_c),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

   // Pipeline datapath: clamp below-min pixels, round the fixed-point product, saturate
   always_comb begin
      diff_c = {i_pixel[NB_PIXEL-1], i_pixel} - {o_minByte[NB_PIXEL-1], o_minByte};
      if (diff_c[NB_RANGE-1]) diff_c = '0;
      rnd_c = (NB_RND'(prod2_q) + NB_RND'(HALF)) >> NB_FRAC;
      rnd_c = rnd_c + NB_RND'(NEW_MIN);
      pix_c = (rnd_c > NB_RND'(NEW_MAX)) ? NB_OUT'(NEW_MAX) : rnd_c[NB_OUT-1:0];
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         v1_q    <= 1'b0;
         d1_q    <= 1'b0;
         diff1_q <= '0;
         v2_q    <= 1'b0;
         d2_q    <= 1'b0;
         prod2_q <= '0;
         o_valid <= 1'b0;
         o_done  <= 1'b0;
         o_pixel <= '0;
      end else begin
         v1_q    <= (state_q == RUN) && i_valid;
         d1_q    <= (state_q == RUN) && i_endSignal;
         v2_q    <= v1_q;
         d2_q    <= d1_q;
         o_valid <= v2_q;
         o_done  <= d2_q;
         if ((state_q == RUN) && i_valid) diff1_q <= diff_c;
         if (v1_q) prod2_q <= NB_PROD'(diff1_q) * NB_PROD'(scale_q);
         if (v2_q) o_pixel <= pix_c;
      end
   end
endmodule
